// File: rtl/spi_master_cfg.sv
// spi_master_cfg
// Parametrised SPI master with configurable word width, CPOL/CPHA mode,
// bit order and power-of-two SCK divider. It also has an on-chip one-hot,
// active-low slave-select decoder.
// A transfer runs LEAD (H cycles), XFER (2*DATA_W SCK edges, one every H
// cycles) and TRAIL (H cycles), then pulses done for one cycle.
//
// Handshake: start is a request that is sampled only while busy=0. When it
// is accepted, busy rises on the next cycle and stays high until the cycle
// in which done pulses. That cycle is also the first cycle in which a new
// start can be accepted. A start seen while busy=1 is dropped.
module spi_master_cfg #(
    parameter int DATA_W    = 8,
    parameter int SS_ADDR_W = 4,
    parameter int NUM_SS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [SS_ADDR_W-1:0] addr,
    input  logic [2:0]           clk_sel,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsb_first,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic [NUM_SS-1:0]    ss_n,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    data_out,
    output logic [1:0]           dbg_state
);

    // The edge counter must hold 2*DATA_W without wrapping.
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_sck;
    logic                r_mosi;
    logic                r_busy;
    logic                r_done;
    logic [NUM_SS-1:0]   r_ss_n;
    logic [DATA_W-1:0]   r_data_out;

    // Shadow copies of the configuration, frozen for the whole frame.
    logic [2:0]          r_clk_sel;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;

    // Transmit bits still to be sent, and the receive accumulator.
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;

    // Half-period countdown. It reloads with H-1, so it reaches zero once
    // every H cycles.
    logic [6:0]          r_half_cnt;
    // Number of SCK edges already produced in this frame.
    logic [EDGE_W-1:0]   r_edge_cnt;

    logic [NUM_SS-1:0]   w_ss_dec;
    logic [6:0]          w_half_m1_in;
    logic [6:0]          w_half_m1;
    logic [EDGE_W-1:0]   w_edge_num;
    logic                w_sample;
    logic                w_shift;
    logic                w_tx_bit;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_next;
    logic                w_in_first_bit;
    logic [DATA_W-1:0]   w_in_shifted;

    // H-1 for the live clk_sel (used at frame start) and for the frozen copy.
    assign w_half_m1_in = 7'((8'd1 << clk_sel) - 8'd1);
    assign w_half_m1    = 7'((8'd1 << r_clk_sel) - 8'd1);

    // The edge that fires when the half-period counter expires. Odd edges
    // are leading edges and even edges are trailing edges.
    assign w_edge_num = r_edge_cnt + EDGE_W'(1);

    // cpha=0 samples on leading edges and shifts on trailing edges, except
    // after the final edge. cpha=1 shifts on leading edges and samples on
    // trailing edges.
    assign w_sample = r_cpha ? ~w_edge_num[0] : w_edge_num[0];
    assign w_shift  = r_cpha ? w_edge_num[0]
                             : (~w_edge_num[0] && (w_edge_num != LAST_EDGE));

    // The next transmit bit comes from whichever end matches the bit order.
    assign w_tx_bit   = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign w_tx_shift = r_lsb ? (r_tx >> 1) : (r_tx << 1);

    // Received bits enter from the end that leaves the first bit correctly
    // placed after DATA_W samples.
    assign w_rx_next = r_lsb ? {miso, r_rx[DATA_W-1:1]}
                             : {r_rx[DATA_W-2:0], miso};

    // With cpha=0 the first bit is driven as soon as the frame starts.
    assign w_in_first_bit = lsb_first ? data_in[0] : data_in[DATA_W-1];
    assign w_in_shifted   = lsb_first ? (data_in >> 1) : (data_in << 1);

    // One-hot active-low decode of the requested slave. Out-of-range
    // addresses match no line, so every select stays high.
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (addr == SS_ADDR_W'(i)) begin
                w_ss_dec[i] = 1'b0;
            end
        end
    end

    // Transfer FSM with all serial and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ss_n     <= '1;
            r_data_out <= '0;
            r_clk_sel  <= 3'd0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_half_cnt <= 7'd0;
            r_edge_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // While idle, SCK tracks the requested polarity so that
                    // a frame starts from the right level.
                    r_sck <= cpol;
                    if (start) begin
                        r_clk_sel  <= clk_sel;
                        r_cpol     <= cpol;
                        r_cpha     <= cpha;
                        r_lsb      <= lsb_first;
                        r_ss_n     <= w_ss_dec;
                        r_busy     <= 1'b1;
                        r_half_cnt <= w_half_m1_in;
                        r_edge_cnt <= '0;
                        r_rx       <= '0;
                        if (!cpha) begin
                            r_mosi <= w_in_first_bit;
                            r_tx   <= w_in_shifted;
                        end else begin
                            r_tx   <= data_in;
                        end
                        r_state <= LEAD;
                    end
                end

                LEAD, XFER: begin
                    if (r_half_cnt == 7'd0) begin
                        r_half_cnt <= w_half_m1;
                        r_sck      <= ~r_sck;
                        r_edge_cnt <= w_edge_num;
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_shift) begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_shift;
                        end
                        if (w_edge_num == LAST_EDGE) begin
                            r_state <= TRAIL;
                        end else begin
                            r_state <= XFER;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt - 7'd1;
                    end
                end

                TRAIL: begin
                    if (r_half_cnt == 7'd0) begin
                        // An even edge count has already returned SCK to its
                        // idle level. Pin it there explicitly anyway.
                        r_sck      <= r_cpol;
                        r_ss_n     <= '1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_data_out <= r_rx;
                        r_edge_cnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_half_cnt <= r_half_cnt - 7'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sck       = r_sck;
    assign mosi      = r_mosi;
    assign ss_n      = r_ss_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign data_out  = r_data_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed testbench for spi_master_cfg. Instance A uses the default build
// (DATA_W=8, NUM_SS=16). Instance B uses DATA_W=16 and NUM_SS=8.
module tb_spi_master_cfg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- instance A signals ----------------
    logic        start_a;
    logic [7:0]  data_in_a;
    logic [3:0]  addr_a;
    logic [2:0]  clk_sel_a;
    logic        cpol_a, cpha_a, lsb_a, miso_a;
    logic        sck_a, mosi_a, busy_a, done_a;
    logic [15:0] ss_n_a;
    logic [7:0]  data_out_a;
    logic [1:0]  dbg_a;

    // ---------------- instance B signals ----------------
    logic        start_b;
    logic [15:0] data_in_b;
    logic [3:0]  addr_b;
    logic [2:0]  clk_sel_b;
    logic        cpol_b, cpha_b, lsb_b, miso_b;
    logic        sck_b, mosi_b, busy_b, done_b;
    logic [7:0]  ss_n_b;
    logic [15:0] data_out_b;
    logic [1:0]  dbg_b;

    spi_master_cfg #(.DATA_W(8), .SS_ADDR_W(4), .NUM_SS(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data_in(data_in_a),
        .addr(addr_a), .clk_sel(clk_sel_a), .cpol(cpol_a), .cpha(cpha_a),
        .lsb_first(lsb_a), .miso(miso_a), .sck(sck_a), .mosi(mosi_a),
        .ss_n(ss_n_a), .busy(busy_a), .done(done_a), .data_out(data_out_a),
        .dbg_state(dbg_a)
    );

    spi_master_cfg #(.DATA_W(16), .SS_ADDR_W(4), .NUM_SS(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data_in(data_in_b),
        .addr(addr_b), .clk_sel(clk_sel_b), .cpol(cpol_b), .cpha(cpha_b),
        .lsb_first(lsb_b), .miso(miso_b), .sck(sck_b), .mosi(mosi_b),
        .ss_n(ss_n_b), .busy(busy_b), .done(done_b), .data_out(data_out_b),
        .dbg_state(dbg_b)
    );

    // ---------------- bookkeeping / scoreboard ----------------
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic        mosi_hist [0:255];

    // ---------------- slave model for instance A ----------------
    // lb=1 loops MOSI back to MISO. Otherwise a mode-aware slave returns
    // s_word LSB first and collects MOSI LSB first into s_rx.
    logic       lb;
    logic       s_miso;
    logic [7:0] s_word;
    logic [7:0] s_rx;
    int         s_idx, s_ridx;
    logic       ss_sel_a;

    assign miso_a   = lb ? mosi_a : s_miso;
    assign miso_b   = mosi_b;
    assign ss_sel_a = ss_n_a[addr_a];

    // Frame start: reset the bit pointers. In mode cpha=0, present bit 0 at once.
    always @(negedge ss_sel_a) begin
        s_idx  = 0;
        s_ridx = 0;
        s_rx   = 8'h00;
        if (!cpha_a) begin
            s_miso = s_word[0];
            s_idx  = 1;
        end
    end

    // Leading edges leave the idle level and trailing edges return to it.
    always @(sck_a) begin
        if (ss_sel_a === 1'b0) begin
            if (sck_a !== cpol_a) begin
                if (cpha_a) begin
                    if (s_idx < 8) s_miso = s_word[s_idx];
                    s_idx++;
                end else begin
                    if (s_ridx < 8) s_rx[s_ridx] = mosi_a;
                    s_ridx++;
                end
            end else begin
                if (cpha_a) begin
                    if (s_ridx < 8) s_rx[s_ridx] = mosi_a;
                    s_ridx++;
                end else begin
                    if (s_idx < 8) s_miso = s_word[s_idx];
                    s_idx++;
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on A from IDLE and checks framing, timing and the
    // received word.
    task automatic run_a(input string tag, input logic [7:0] d, input logic [3:0] a,
                         input logic [2:0] cs, input logic cp, input logic ch,
                         input logic lsb, input logic [15:0] exp_ss,
                         input logic [7:0] exp_d, input int exp_lat);
        int   lat, tog, ss_bad;
        logic prev;
        data_in_a = d; addr_a = a; clk_sel_a = cs;
        cpol_a = cp; cpha_a = ch; lsb_a = lsb;
        exp_q.push_back(16'(exp_d));
        tick();
        chk({tag, ".idle_sck"}, 32'(sck_a), 32'(cp));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, ".t1_busy"}, 32'(busy_a), 32'd1);
        chk({tag, ".t1_ss"}, 32'(ss_n_a), 32'(exp_ss));
        chk({tag, ".t1_sck"}, 32'(sck_a), 32'(cp));
        lat = 0; tog = 0; ss_bad = 0; prev = sck_a;
        while (done_a !== 1'b1 && lat < 5000) begin
            if (lat < 256) mosi_hist[lat] = mosi_a;
            if (ss_n_a !== exp_ss || busy_a !== 1'b1) ss_bad++;
            tick();
            lat++;
            if (sck_a !== prev) tog++;
            prev = sck_a;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".sck_toggles"}, 32'(tog), 32'd16);
        chk({tag, ".ss_during"}, 32'(ss_bad), 32'd0);
        chk({tag, ".done_ss"}, 32'(ss_n_a), 32'hFFFF);
        chk({tag, ".done_busy"}, 32'(busy_a), 32'd0);
        chk({tag, ".done_sck"}, 32'(sck_a), 32'(cp));
        chk({tag, ".data_out"}, 32'(data_out_a), 32'(exp_q.pop_front()));
        tick();
        chk({tag, ".done_pulse"}, 32'(done_a), 32'd0);
    endtask

    // Runs one loopback frame on B.
    task automatic run_b(input string tag, input logic [15:0] d, input logic [3:0] a,
                         input logic [2:0] cs, input logic cp, input logic ch,
                         input logic lsb, input logic [7:0] exp_ss, input int exp_lat);
        int   lat, tog, ss_bad;
        logic prev;
        data_in_b = d; addr_b = a; clk_sel_b = cs;
        cpol_b = cp; cpha_b = ch; lsb_b = lsb;
        exp_q.push_back(d);
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk({tag, ".t1_busy"}, 32'(busy_b), 32'd1);
        lat = 0; tog = 0; ss_bad = 0; prev = sck_b;
        while (done_b !== 1'b1 && lat < 6000) begin
            if (ss_n_b !== exp_ss) ss_bad++;
            tick();
            lat++;
            if (sck_b !== prev) tog++;
            prev = sck_b;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".sck_toggles"}, 32'(tog), 32'd32);
        chk({tag, ".ss_during"}, 32'(ss_bad), 32'd0);
        chk({tag, ".done_ss"}, 32'(ss_n_b), 32'hFF);
        chk({tag, ".data_out"}, 32'(data_out_b), 32'(exp_q.pop_front()));
    endtask

    // Absolute time bound, in case something upstream stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          n, bad;
        logic [7:0]  w;

        rst = 1'b1;
        start_a = 1'b0; data_in_a = '0; addr_a = '0; clk_sel_a = '0;
        cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
        start_b = 1'b0; data_in_b = '0; addr_b = '0; clk_sel_b = '0;
        cpol_b = 1'b0; cpha_b = 1'b0; lsb_b = 1'b0;
        lb = 1'b1; s_miso = 1'b0; s_word = 8'h3C; s_rx = 8'h00;
        s_idx = 0; s_ridx = 0;

        // Reset state.
        tick(); tick();
        chk("rst.sck", 32'(sck_a), 32'd0);
        chk("rst.mosi", 32'(mosi_a), 32'd0);
        chk("rst.ss_n", 32'(ss_n_a), 32'hFFFF);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.done", 32'(done_a), 32'd0);
        chk("rst.data_out", 32'(data_out_a), 32'd0);
        chk("rst.ss_n_b", 32'(ss_n_b), 32'hFF);
        rst = 1'b0;
        tick();

        // Mode 0, MSB first, H=1, loopback, addr 3.
        lb = 1'b1;
        run_a("m0_a5", 8'hA5, 4'd3, 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFF7, 8'hA5, 17);
        w = 8'h00;
        for (int j = 0; j < 8; j++) w[7-j] = mosi_hist[2*j];
        chk("m0_a5.mosi_pattern", 32'(w), 32'hA5);
        chk("m0_a5.mosi_hold", 32'(mosi_a), 32'd1);

        // All four modes, LSB first, H=4, slave returns 0x3C.
        lb = 1'b0;
        run_a("mode0", 8'h96, 4'd5, 3'd2, 1'b0, 1'b0, 1'b1, 16'hFFDF, 8'h3C, 68);
        chk("mode0.slave_rx", 32'(s_rx), 32'h96);
        run_a("mode1", 8'h4B, 4'd5, 3'd2, 1'b0, 1'b1, 1'b1, 16'hFFDF, 8'h3C, 68);
        chk("mode1.slave_rx", 32'(s_rx), 32'h4B);
        run_a("mode2", 8'hE1, 4'd5, 3'd2, 1'b1, 1'b0, 1'b1, 16'hFFDF, 8'h3C, 68);
        chk("mode2.slave_rx", 32'(s_rx), 32'hE1);
        run_a("mode3", 8'h2D, 4'd5, 3'd2, 1'b1, 1'b1, 1'b1, 16'hFFDF, 8'h3C, 68);
        chk("mode3.slave_rx", 32'(s_rx), 32'h2D);

        // Mid-frame start and config changes are ignored. A start held
        // through done launches a second frame.
        lb = 1'b1;
        data_in_a = 8'h5A; addr_a = 4'd2; clk_sel_a = 3'd0;
        cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        data_in_a = 8'hC3; addr_a = 4'd9; cpha_a = 1'b1; lsb_a = 1'b1;
        n = 0; bad = 0;
        while (done_a !== 1'b1 && n < 100) begin
            if (ss_n_a !== 16'hFFFB) bad++;
            if (n == 5) start_a = 1'b1;
            else if (n == 6) start_a = 1'b0;
            else if (n == 15) start_a = 1'b1;
            tick();
            n++;
        end
        chk("b2b.latency1", 32'(n), 32'd17);
        chk("b2b.ss_during1", 32'(bad), 32'd0);
        chk("b2b.data_out1", 32'(data_out_a), 32'h5A);
        chk("b2b.gap_ss", 32'(ss_n_a), 32'hFFFF);
        tick();
        start_a = 1'b0;
        chk("b2b.busy2", 32'(busy_a), 32'd1);
        chk("b2b.ss2", 32'(ss_n_a), 32'hFDFF);
        n = 0;
        while (done_a !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b.latency2", 32'(n), 32'd17);
        chk("b2b.data_out2", 32'(data_out_a), 32'hC3);
        repeat (3) tick();
        chk("b2b.no_queue", 32'(busy_a), 32'd0);

        // Reset at the cycle that would produce edge 5.
        data_in_a = 8'h69; addr_a = 4'd1; clk_sel_a = 3'd0;
        cpol_a = 1'b1; cpha_a = 1'b0; lsb_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.ss_n", 32'(ss_n_a), 32'hFFFF);
        chk("abort.busy", 32'(busy_a), 32'd0);
        chk("abort.sck", 32'(sck_a), 32'd0);
        chk("abort.data_out", 32'(data_out_a), 32'd0);
        n = 0;
        repeat (25) begin
            if (done_a !== 1'b0) n++;
            tick();
        end
        chk("abort.no_done", 32'(n), 32'd0);
        run_a("after_abort", 8'h69, 4'd1, 3'd0, 1'b1, 1'b0, 1'b0, 16'hFFFD, 8'h69, 17);

        // DATA_W=16 build: slowest divider, then an out-of-range address.
        run_b("w16_slow", 16'hC3A5, 4'd3, 3'd7, 1'b1, 1'b1, 1'b1, 8'hF7, 4224);
        run_b("w16_noss", 16'h1E5A, 4'd15, 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
